contador_prescaler_mod: RTL

Parametrised successor to the fixed divided-clock counter: a single-clock, up/down, modulo-N counter advanced by an internal prescaler tick. It adds synchronous load, terminal-count and tick strobes, and an optional 7-segment decode. It sits between the 50 MHz board clock domain and display/timing logic, and is the standard time-base counter for the practice designs.

---
 rtl/contador_pkg.sv | 64 ++++++
 rtl/contador_prescaler_mod_divisor_tick.sv | 38 +++
 rtl/contador_prescaler_mod.sv | 105 ++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the prescaled modulo counter: divider computation,
// configuration legality check and the active-low gfedcba 7-segment decode.
package contador_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic longint calc_div(input longint clk_hz, input longint tick_hz);
    if (tick_hz <= 64'sd0) begin
      return 64'sd1;
    end else if (clk_hz / tick_hz < 64'sd1) begin
      return 64'sd1;
    end else begin
      return clk_hz / tick_hz;
    end
  endfunction

  // Integral divider of at least 1 and a modulo that fits the counter width.
  function automatic bit cfg_ok(input longint clk_hz, input longint tick_hz,
                                input longint modulo, input longint width);
    bit ok;
    ok = 1'b1;
    if (tick_hz <= 64'sd0 || clk_hz < tick_hz) begin
      ok = 1'b0;
    end else if (clk_hz % tick_hz != 64'sd0) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if (width < 64'sd1 || width > 64'sd62) begin
      ok = 1'b0;
    end else if (modulo < 64'sd2 || modulo > (64'sd1 <<< width)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_prescaler_mod_divisor_tick.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags the cycle that completes
// a period; clr restarts the period and suppresses that flag.
module divisor_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic adv
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(32'd1);

  logic [PW-1:0] pre_r;

  assign adv = en & ~clr & (pre_r == LAST);

  // Prescaler state; holds while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= {PW{1'b0}};
    end else if (clr) begin
      pre_r <= {PW{1'b0}};
    end else if (en) begin
      if (pre_r == LAST) begin
        pre_r <= {PW{1'b0}};
      end else begin
        pre_r <= pre_r + ONE;
      end
    end else begin
      pre_r <= pre_r;
    end
  end

endmodule

// File: rtl/contador_prescaler_mod.sv
// Up/down modulo-N counter advanced by a prescaler tick, with clamped load and
// tick/tc strobes. Define CONTADOR_SEG7_EN to add the registered seg output.
module contador_prescaler_mod
  import contador_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
`ifdef CONTADOR_SEG7_EN
  output logic             tc,
  output logic [6:0]       seg
`else
  output logic             tc
`endif
);

  localparam int DIV = int'(calc_div(longint'(CLK_HZ), longint'(TICK_HZ)));
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(32'd1);

  if (!cfg_ok(longint'(CLK_HZ), longint'(TICK_HZ), longint'(MODULO), longint'(WIDTH))) begin : g_cfg_err
    $error("contador_prescaler_mod: illegal CLK_HZ/TICK_HZ/MODULO/WIDTH combination");
  end

  logic             adv_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tick_nxt_s;
  logic             tc_nxt_s;

  divisor_tick #(.DIV(DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .adv (adv_s)
  );

  // Next count and strobes; load wins over a coincident advance.
  always_comb begin
    count_nxt_s = count;
    tick_nxt_s  = 1'b0;
    tc_nxt_s    = 1'b0;
    if (load) begin
      count_nxt_s = (load_val > MAXV) ? MAXV : load_val;
    end else if (adv_s) begin
      tick_nxt_s = 1'b1;
      if (up_dn) begin
        if (count == MAXV) begin
          count_nxt_s = {WIDTH{1'b0}};
          tc_nxt_s    = 1'b1;
        end else begin
          count_nxt_s = count + ONE;
        end
      end else begin
        if (count == {WIDTH{1'b0}}) begin
          count_nxt_s = MAXV;
          tc_nxt_s    = 1'b1;
        end else begin
          count_nxt_s = count - ONE;
        end
      end
    end else begin
      count_nxt_s = count;
    end
  end

  // Registered count and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {WIDTH{1'b0}};
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt_s;
      tick  <= tick_nxt_s;
      tc    <= tc_nxt_s;
    end
  end

`ifdef CONTADOR_SEG7_EN
  if (WIDTH < 4) begin : g_seg_err
    $error("contador_prescaler_mod: CONTADOR_SEG7_EN requires WIDTH >= 4");
  end

  // Display decode tracks the count register edge for edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_ZERO;
    end else begin
      seg <= seg7(count_nxt_s[3:0]);
    end
  end
`endif

endmodule
